// File: rtl/req_rw_arb.sv
// Per-channel read/write request merger: two request FIFOs feeding one registered output.
// Optional write anti-starvation counter is enabled by defining VECTOR_CACHE_RW_ARB_STARVE_EN.

package req_rw_arb_pkg;
  typedef struct packed {
    logic        cmd_opcode;  // 1 = read, 0 = write
    logic [7:0]  src_id;
    logic [31:0] addr;
    logic [31:0] data;
  } input_req_pld_t;
endpackage

module req_rw_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld_i,
  input  logic [W-1:0]               din_i,
  output logic                       rdy_o,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;

  assign rdy_o  = (cnt_q != CW'(DEPTH));
  assign push   = vld_i && rdy_o;
  assign dout_o = mem_q[rptr_q];
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally (DEPTH is a power of two); the counter resolves full vs empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)  wptr_q <= wptr_q + AW'(1);
      if (pop_i) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din_i;
  end
endmodule

module req_rw_arb
  import req_rw_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_vld,
  input  input_req_pld_t                rd_pld,
  output logic                          rd_rdy,
  input  logic                          wr_vld,
  input  input_req_pld_t                wr_pld,
  output logic                          wr_rdy,
  output logic                          out_vld,
  output input_req_pld_t                out_pld,
  input  logic                          out_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   rd_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   wr_cnt
);
  localparam int PW = $bits(input_req_pld_t);

  logic [PW-1:0]  rd_dout, wr_dout;
  logic           rd_ne, wr_ne, load, gnt_rd, gnt_wr, force_wr;
  logic           out_vld_q, out_vld_d;
  input_req_pld_t out_pld_q, out_pld_d;

  req_rw_arb_fifo #(.DEPTH(FIFO_DEPTH), .W(PW)) u_rd_fifo (
    .clk(clk), .rst(rst), .vld_i(rd_vld), .din_i(rd_pld), .rdy_o(rd_rdy),
    .pop_i(load && gnt_rd), .dout_o(rd_dout), .cnt_o(rd_cnt)
  );

  req_rw_arb_fifo #(.DEPTH(FIFO_DEPTH), .W(PW)) u_wr_fifo (
    .clk(clk), .rst(rst), .vld_i(wr_vld), .din_i(wr_pld), .rdy_o(wr_rdy),
    .pop_i(load && gnt_wr), .dout_o(wr_dout), .cnt_o(wr_cnt)
  );

  // Arbitration uses registered occupancy, so a same-cycle push is seen next cycle.
  assign rd_ne  = (rd_cnt != '0);
  assign wr_ne  = (wr_cnt != '0);
  assign load   = !out_vld_q || out_rdy;
  assign gnt_wr = wr_ne && (!rd_ne || force_wr);
  assign gnt_rd = rd_ne && !gnt_wr;

`ifdef VECTOR_CACHE_RW_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign force_wr = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!wr_ne)                 starve_d = '0;
    else if (load && gnt_wr)    starve_d = '0;
    else if (load && gnt_rd)    starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  // No counter: writes only take slots the read stream leaves idle.
  assign force_wr = (STARVE_LIMIT == 0) & 1'b0;
`endif

  always_comb begin
    out_vld_d = out_vld_q;
    out_pld_d = out_pld_q;
    if (load) begin
      out_vld_d = gnt_rd || gnt_wr;
      if (gnt_rd)      out_pld_d = input_req_pld_t'(rd_dout);
      else if (gnt_wr) out_pld_d = input_req_pld_t'(wr_dout);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_pld_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_pld_q <= out_pld_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_pld = out_pld_q;
endmodule

// File: tb/tb_req_rw_arb.sv
// Scoreboard bench for req_rw_arb: accepted requests queued per stream, monitor checks outputs.
module tb_req_rw_arb;
  import req_rw_arb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rd_vld, wr_vld, out_rdy;
  input_req_pld_t rd_pld, wr_pld, out_pld;
  logic           rd_rdy, wr_rdy, out_vld;
  logic [2:0]     rd_cnt, wr_cnt;

  req_rw_arb #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .rd_vld(rd_vld), .rd_pld(rd_pld), .rd_rdy(rd_rdy),
    .wr_vld(wr_vld), .wr_pld(wr_pld), .wr_rdy(wr_rdy),
    .out_vld(out_vld), .out_pld(out_pld), .out_rdy(out_rdy),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int             total = 0;
  int             bad   = 0;
  int             n_out = 0;
  input_req_pld_t rd_exp[$];
  input_req_pld_t wr_exp[$];
  logic           seq_q[$];
  logic           seq_on = 1'b0;
  logic           hold = 1'b0;
  input_req_pld_t hold_pld;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic input_req_pld_t mk(input logic op, input logic [31:0] addr);
    input_req_pld_t p;
    p.cmd_opcode = op;
    p.src_id     = addr[7:0] ^ 8'h5a;
    p.addr       = addr;
    p.data       = ~addr;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepted requests become the expected responses for their stream.
  always @(negedge clk) begin
    if (rst) begin
      rd_exp.delete();
      wr_exp.delete();
    end else begin
      if (rd_vld && rd_rdy) rd_exp.push_back(rd_pld);
      if (wr_vld && wr_rdy) wr_exp.push_back(wr_pld);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_vld", out_vld, 1'b1);
        chk("hold_pld", out_pld, hold_pld);
      end
      if (out_vld && out_rdy) begin
        n_out++;
        if (seq_on) seq_q.push_back(out_pld.cmd_opcode);
        if (out_pld.cmd_opcode) begin
          if (rd_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got %0h want none", out_pld);
          end else chk("rd_order", out_pld, rd_exp.pop_front());
        end else begin
          if (wr_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected: got %0h want none", out_pld);
          end else chk("wr_order", out_pld, wr_exp.pop_front());
        end
      end
      hold     = out_vld && !out_rdy;
      hold_pld = out_pld;
    end
  end

  task automatic drain(input string name);
    int k;
    rd_vld  = 1'b0;
    wr_vld  = 1'b0;
    out_rdy = 1'b1;
    for (k = 0; k < 60; k++) begin
      if (!out_vld && rd_cnt == 0 && wr_cnt == 0) break;
      step();
    end
    chk({name, "_timeout"}, (k < 60), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, nwr;
    rd_vld = 1'b0; wr_vld = 1'b0; out_rdy = 1'b1;
    rd_pld = '0;   wr_pld = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_pld", out_pld, '0);
    chk("rst_rd_rdy", rd_rdy, 1'b1);
    chk("rst_wr_rdy", wr_rdy, 1'b1);
    chk("rst_rd_cnt", rd_cnt, 3'd0);
    chk("rst_wr_cnt", wr_cnt, 3'd0);
    rst = 1'b0;
    step();

    // Single read: visible after the second edge.
    rd_pld = mk(1'b1, 32'h4000);
    rd_vld = 1'b1;
    step();
    rd_vld = 1'b0;
    chk("lat_vld_early", out_vld, 1'b0);
    chk("lat_rd_cnt1", rd_cnt, 3'd1);
    step();
    chk("lat_vld", out_vld, 1'b1);
    chk("lat_addr", out_pld.addr, 32'h4000);
    chk("lat_rd_cnt0", rd_cnt, 3'd0);
    step();

    // Backpressure: 1 in the output register, 4 in the FIFO.
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_pld = mk(1'b1, 32'h5000 + i);
      rd_vld = 1'b1;
      step();
    end
    rd_vld = 1'b0;
    chk("bp_rd_cnt", rd_cnt, 3'd4);
    chk("bp_rd_rdy", rd_rdy, 1'b0);
    chk("bp_out_vld", out_vld, 1'b1);
    chk("bp_head", out_pld.addr, 32'h5000);
    out_rdy = 1'b1;
    n0 = n_out;
    repeat (5) step();
    chk("bp_burst5", n_out - n0, 5);
    chk("bp_empty_vld", out_vld, 1'b0);
    chk("bp_empty_cnt", rd_cnt, 3'd0);

    // Both streams continuously valid.
    seq_q.delete();
    seq_on = 1'b1;
    for (int c = 0; c < 36; c++) begin
      rd_pld = mk(1'b1, 32'h6000 + c);
      wr_pld = mk(1'b0, 32'h7000 + c);
      rd_vld = 1'b1;
      wr_vld = 1'b1;
      step();
`ifndef VECTOR_CACHE_RW_ARB_STARVE_EN
      if (c >= 4) chk("cont_wr_rdy", wr_rdy, 1'b0);
`endif
    end
    rd_vld = 1'b0;
    wr_vld = 1'b0;
    seq_on = 1'b0;
    chk("cont_seq_len", seq_q.size() >= 30, 1'b1);
`ifdef VECTOR_CACHE_RW_ARB_STARVE_EN
    for (int i = 0; i < 27 && i < seq_q.size(); i++)
      chk("starve_pattern", seq_q[i], (i % (LIM + 1)) != LIM);
`else
    nwr = 0;
    foreach (seq_q[i]) if (!seq_q[i]) nwr++;
    chk("cont_no_writes", nwr, 0);
    chk("cont_wr_cnt", wr_cnt, 3'd4);
`endif
    drain("cont_drain");

    // Reset while both FIFOs hold 3 entries and the output is held.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_pld = mk(1'b1, 32'h8000 + i);
      wr_pld = mk(1'b0, 32'h9000 + i);
      rd_vld = 1'b1;
      wr_vld = (i < 3);
      step();
    end
    rd_vld = 1'b0;
    wr_vld = 1'b0;
    chk("pre_rst_rd_cnt", rd_cnt, 3'd3);
    chk("pre_rst_wr_cnt", wr_cnt, 3'd3);
    chk("pre_rst_vld", out_vld, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_vld, 1'b0);
    chk("mid_rst_rd_cnt", rd_cnt, 3'd0);
    chk("mid_rst_wr_cnt", wr_cnt, 3'd0);
    step();
    rst = 1'b0;
    out_rdy = 1'b1;
    n0 = n_out;
    repeat (6) step();
    chk("no_stale_out", n_out - n0, 0);
    chk("no_stale_vld", out_vld, 1'b0);

    // Random traffic and backpressure.
    for (int c = 0; c < 3000; c++) begin
      rd_pld  = mk(1'b1, 32'h1_0000 + c);
      wr_pld  = mk(1'b0, 32'h2_0000 + c);
      rd_vld  = ($urandom_range(0, 2) != 0);
      wr_vld  = ($urandom_range(0, 1) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand_drain");
    chk("rand_rd_left", rd_exp.size(), 0);
    chk("rand_wr_left", wr_exp.size(), 0);
    chk("rand_outputs", n_out > 1000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
